// File: rtl/nn_pkg.sv
// Shared types and arithmetic helpers for the single-layer training datapath.
package nn_pkg;

    localparam int unsigned DefDw = 8;
    localparam int unsigned DefLw = 12;

    typedef enum logic [1:0] {StIdle, StFwd, StBwd, StDone} state_e;
    typedef enum logic [1:0] {KindF0, KindF1, KindB} pass_kind_e;

    // Index width that stays at least one bit for single-entry ranges.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Clamp v into the signed w-bit range; all operands here fit in 32 bits.
    function automatic int sat_dw(input int v, input int unsigned w);
        int hi;
        int lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Clamp v into the unsigned w-bit range.
    function automatic int sat_lw(input int v, input int unsigned w);
        int hi;
        hi = (1 << w) - 1;
        if (v > hi) return hi;
        if (v < 0) return 0;
        return v;
    endfunction

endpackage

// File: rtl/weight_regfile.sv
// Weight and delta storage with one shared read/write address and a bulk commit.
module weight_regfile
    import nn_pkg::*;
#(
    parameter int unsigned NW = 4,
    parameter int unsigned DW = DefDw,
    parameter int unsigned AW = idx_width(NW)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [AW-1:0]        addr_i,
    input  logic                 w_we_i,
    input  logic signed [DW-1:0] w_wdata_i,
    input  logic                 d_we_i,
    input  logic signed [DW-1:0] d_wdata_i,
    input  logic                 d_clr_i,
    input  logic                 commit_i,
    output logic signed [DW-1:0] w_rdata_o
);

    logic signed [DW-1:0] w_q [NW];
    logic signed [DW-1:0] d_q [NW];

    // Storage update; commit folds every delta into its weight on one edge.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int unsigned k = 0; k < NW; k++) begin
                w_q[k] <= '0;
                d_q[k] <= '0;
            end
        end else if (en_i) begin
            for (int unsigned k = 0; k < NW; k++) begin
                if (commit_i) begin
                    w_q[k] <= DW'(sat_dw(int'(w_q[k]) + int'(d_q[k]), DW));
                end else if (w_we_i && 32'(addr_i) == k) begin
                    w_q[k] <= w_wdata_i;
                end
                if (d_clr_i) begin
                    d_q[k] <= '0;
                end else if (d_we_i && 32'(addr_i) == k) begin
                    d_q[k] <= d_wdata_i;
                end
            end
        end
    end

    // Asynchronous read of the addressed weight; out-of-range reads return 0.
    always_comb begin
        w_rdata_o = '0;
        for (int unsigned k = 0; k < NW; k++) begin
            if (32'(addr_i) == k) w_rdata_o = w_q[k];
        end
    end

endmodule

// File: rtl/pass_engine.sv
// Serial MAC engine running forward and backward passes of a single-layer network.
module pass_engine
    import nn_pkg::*;
#(
    parameter int unsigned N_IN     = 2,
    parameter int unsigned N_OUT    = 2,
    parameter int unsigned DW       = DefDw,
    parameter int unsigned LW       = DefLw,
    parameter int unsigned LR_SHIFT = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                en_i,
    input  logic                                f0_pass_i,
    input  logic                                f1_pass_i,
    input  logic                                b_pass_i,
    input  logic                                zero_loss_i,
    input  logic                                zero_final_i,
    input  logic                                zero_weight_update_i,
    input  logic [N_IN*DW-1:0]                  x_i,
    input  logic [N_OUT*DW-1:0]                 target_i,
    input  logic                                w_load_i,
    input  logic [idx_width(N_IN*N_OUT)-1:0]    w_addr_i,
    input  logic [DW-1:0]                       w_data_i,
    output logic [N_OUT*DW-1:0]                 y_o,
    output logic [LW-1:0]                       loss_o,
    output logic                                f_end_o,
    output logic                                b_end_o,
    output logic                                zero_end_check_o,
    output logic                                busy_o
);

    localparam int unsigned NW   = N_IN * N_OUT;
    localparam int unsigned AW   = idx_width(NW);
    localparam int unsigned IW   = idx_width(N_IN + 1);
    localparam int unsigned JW   = idx_width(N_OUT + 1);
    localparam int unsigned AccW = 2 * DW + idx_width(N_IN);
    localparam int unsigned EW   = DW + 1;

    state_e               state_q, state_d;
    pass_kind_e           kind_q, kind_d;
    logic [IW-1:0]        i_q, i_d;
    logic [JW-1:0]        j_q, j_d;
    logic signed [AccW-1:0] acc_q, acc_d;
    logic signed [DW-1:0] y_q [N_OUT];
    logic signed [DW-1:0] y_d [N_OUT];
    logic signed [EW-1:0] e_q [N_OUT];
    logic signed [EW-1:0] e_d [N_OUT];
    logic [LW-1:0]        loss_q, loss_d;
    logic                 f_end_q, f_end_d, b_end_q, b_end_d;
    logic                 zec_q, zec_d, busy_q, busy_d;

    logic [AW-1:0]        rf_addr;
    logic                 rf_w_we, rf_d_we, rf_d_clr;
    logic signed [DW-1:0] rf_d_wdata, rf_rdata;
    logic signed [DW-1:0] x_sel, t_sel, y_new;
    logic signed [EW-1:0] e_sel, e_new;
    int                   abs_e;

    weight_regfile #(
        .NW (NW),
        .DW (DW),
        .AW (AW)
    ) u_regfile (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .en_i      (en_i),
        .addr_i    (rf_addr),
        .w_we_i    (rf_w_we),
        .w_wdata_i (w_data_i),
        .d_we_i    (rf_d_we),
        .d_wdata_i (rf_d_wdata),
        .d_clr_i   (rf_d_clr),
        .commit_i  (b_end_q),
        .w_rdata_o (rf_rdata)
    );

    // Operand selection by the current (j,i) position and the FIN-step arithmetic.
    always_comb begin
        x_sel = '0;
        t_sel = '0;
        e_sel = '0;
        for (int unsigned k = 0; k < N_IN; k++) begin
            if (32'(i_q) == k) x_sel = x_i[k*DW +: DW];
        end
        for (int unsigned k = 0; k < N_OUT; k++) begin
            if (32'(j_q) == k) begin
                t_sel = target_i[k*DW +: DW];
                e_sel = e_q[k];
            end
        end
        y_new = DW'(sat_dw(int'(acc_q), DW));
        e_new = EW'(int'(t_sel) - int'(y_new));
        abs_e = (e_new < 0) ? -int'(e_new) : int'(e_new);
    end

    // Next-state logic: pass acceptance, MAC/FIN/delta stepping and clear strobes.
    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        i_d        = i_q;
        j_d        = j_q;
        acc_d      = acc_q;
        y_d        = y_q;
        e_d        = e_q;
        loss_d     = loss_q;
        zec_d      = zec_q;
        f_end_d    = 1'b0;
        b_end_d    = 1'b0;
        busy_d     = (state_q == StFwd) || (state_q == StBwd);
        rf_addr    = AW'(32'(j_q) * N_IN + 32'(i_q));
        rf_w_we    = 1'b0;
        rf_d_we    = 1'b0;
        rf_d_clr   = 1'b0;
        rf_d_wdata = DW'(sat_dw((int'(e_sel) * int'(x_sel)) >>> LR_SHIFT, DW));

        unique case (state_q)
            StIdle: begin
                rf_addr = w_addr_i;
                rf_w_we = w_load_i;
                i_d     = '0;
                j_d     = '0;
                acc_d   = '0;
                if (b_pass_i) begin
                    kind_d  = KindB;
                    state_d = StBwd;
                end else if (f1_pass_i) begin
                    kind_d  = KindF1;
                    state_d = StFwd;
                end else if (f0_pass_i) begin
                    kind_d  = KindF0;
                    state_d = StFwd;
                end
            end
            StFwd: begin
                if (32'(j_q) == N_OUT) begin
                    // Completion step sees the final loss of this pass.
                    state_d = StDone;
                    if (kind_q == KindF1 && loss_q == '0) zec_d = 1'b1;
                    else f_end_d = 1'b1;
                end else if (32'(i_q) < N_IN) begin
                    acc_d = AccW'(int'(acc_q) + int'(rf_rdata) * int'(x_sel));
                    i_d   = i_q + 1'b1;
                end else begin
                    for (int unsigned k = 0; k < N_OUT; k++) begin
                        if (32'(j_q) == k) begin
                            y_d[k] = y_new;
                            e_d[k] = e_new;
                        end
                    end
                    loss_d = LW'(sat_lw(int'(loss_q) + abs_e, LW));
                    acc_d  = '0;
                    i_d    = '0;
                    j_d    = j_q + 1'b1;
                end
            end
            StBwd: begin
                if (32'(j_q) == N_OUT) begin
                    b_end_d = 1'b1;
                    state_d = StDone;
                end else begin
                    rf_d_we = 1'b1;
                    if (32'(i_q) == N_IN - 1) begin
                        i_d = '0;
                        j_d = j_q + 1'b1;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end
            end
            StDone: begin
                if (!(f0_pass_i || f1_pass_i || b_pass_i)) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (state_q == StIdle || state_q == StDone) begin
            if (zero_loss_i) begin
                loss_d = '0;
                zec_d  = 1'b0;
            end
            if (zero_final_i) begin
                for (int unsigned k = 0; k < N_OUT; k++) begin
                    y_d[k] = '0;
                    e_d[k] = '0;
                end
            end
            rf_d_clr = zero_weight_update_i;
        end
    end

    // State registers; en_i low freezes everything, including pending pulses.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            kind_q  <= KindF0;
            i_q     <= '0;
            j_q     <= '0;
            acc_q   <= '0;
            loss_q  <= '0;
            f_end_q <= 1'b0;
            b_end_q <= 1'b0;
            zec_q   <= 1'b0;
            busy_q  <= 1'b0;
            for (int unsigned k = 0; k < N_OUT; k++) begin
                y_q[k] <= '0;
                e_q[k] <= '0;
            end
        end else if (en_i) begin
            state_q <= state_d;
            kind_q  <= kind_d;
            i_q     <= i_d;
            j_q     <= j_d;
            acc_q   <= acc_d;
            loss_q  <= loss_d;
            f_end_q <= f_end_d;
            b_end_q <= b_end_d;
            zec_q   <= zec_d;
            busy_q  <= busy_d;
            y_q     <= y_d;
            e_q     <= e_d;
        end
    end

    // Output packing; a due pulse only shows while enabled.
    always_comb begin
        y_o = '0;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            y_o[k*DW +: DW] = y_q[k];
        end
        loss_o           = loss_q;
        f_end_o          = f_end_q & en_i;
        b_end_o          = b_end_q & en_i;
        zero_end_check_o = zec_q;
        busy_o           = busy_q;
    end

endmodule

// File: tb/tb_pass_engine.sv
// Directed bench for pass_engine with default parameters.
module tb_pass_engine;

    logic        clk = 1'b0;
    logic        rst_i, en_i;
    logic        f0_pass_i, f1_pass_i, b_pass_i;
    logic        zero_loss_i, zero_final_i, zero_weight_update_i;
    logic [15:0] x_i, target_i;
    logic        w_load_i;
    logic [1:0]  w_addr_i;
    logic [7:0]  w_data_i;
    logic [15:0] y_o;
    logic [11:0] loss_o;
    logic        f_end_o, b_end_o, zero_end_check_o, busy_o;

    int checks   = 0;
    int failures = 0;

    pass_engine dut (
        .clk_i                (clk),
        .rst_i                (rst_i),
        .en_i                 (en_i),
        .f0_pass_i            (f0_pass_i),
        .f1_pass_i            (f1_pass_i),
        .b_pass_i             (b_pass_i),
        .zero_loss_i          (zero_loss_i),
        .zero_final_i         (zero_final_i),
        .zero_weight_update_i (zero_weight_update_i),
        .x_i                  (x_i),
        .target_i             (target_i),
        .w_load_i             (w_load_i),
        .w_addr_i             (w_addr_i),
        .w_data_i             (w_data_i),
        .y_o                  (y_o),
        .loss_o               (loss_o),
        .f_end_o              (f_end_o),
        .b_end_o              (b_end_o),
        .zero_end_check_o     (zero_end_check_o),
        .busy_o               (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic load_w(input logic [1:0] a, input logic [7:0] d);
        w_addr_i = a;
        w_data_i = d;
        w_load_i = 1'b1;
        @(negedge clk);
        w_load_i = 1'b0;
    endtask

    task automatic strobe(input logic zl, input logic zf, input logic zw);
        zero_loss_i          = zl;
        zero_final_i         = zf;
        zero_weight_update_i = zw;
        @(negedge clk);
        zero_loss_i          = 1'b0;
        zero_final_i         = 1'b0;
        zero_weight_update_i = 1'b0;
    endtask

    // kind: 0 = f_end pulse, 1 = zero_end_check rise, 2 = b_end pulse.
    // gap_at >= 0 drops en_i for the three edges after that cycle.
    task automatic do_pass(input string tag, input logic rq0, input logic rq1, input logic rqb,
                           input int exp_cyc, input int exp_kind, input int gap_at);
        int   got_cyc  = -1;
        int   got_kind = -1;
        int   extra    = 0;
        int   k;
        logic zec_prev;
        logic busy_end = 1'b0;
        zec_prev  = zero_end_check_o;
        f0_pass_i = rq0;
        f1_pass_i = rq1;
        b_pass_i  = rqb;
        for (int c = 0; c < 24 && got_cyc < 0; c++) begin
            @(negedge clk);
            if (c == 0) check_eq({tag, ".busy_c0"}, 32'(busy_o), 32'd0);
            if (c == 1) check_eq({tag, ".busy_c1"}, 32'(busy_o), 32'd1);
            k = -1;
            if (f_end_o) k = 0;
            else if (b_end_o) k = 2;
            else if (zero_end_check_o && !zec_prev) k = 1;
            if (k >= 0) begin
                got_cyc  = c;
                got_kind = k;
                busy_end = busy_o;
            end
            zec_prev = zero_end_check_o;
            if (gap_at >= 0 && c == gap_at) en_i = 1'b0;
            if (gap_at >= 0 && c == gap_at + 3) en_i = 1'b1;
        end
        en_i = 1'b1;
        check_eq({tag, ".end_cycle"}, got_cyc, exp_cyc);
        check_eq({tag, ".end_kind"}, got_kind, exp_kind);
        check_eq({tag, ".busy_end"}, 32'(busy_end), 32'd1);
        // Request levels stay high: no rerun may start.
        for (int h = 0; h < 4; h++) begin
            @(negedge clk);
            if (f_end_o || b_end_o) extra++;
        end
        check_eq({tag, ".no_rerun_pulse"}, extra, 0);
        check_eq({tag, ".no_rerun_busy"}, 32'(busy_o), 32'd0);
        f0_pass_i = 1'b0;
        f1_pass_i = 1'b0;
        b_pass_i  = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int exp_loss;
        rst_i = 1'b0;
        en_i = 1'b1;
        f0_pass_i = 1'b0;
        f1_pass_i = 1'b0;
        b_pass_i = 1'b0;
        zero_loss_i = 1'b0;
        zero_final_i = 1'b0;
        zero_weight_update_i = 1'b0;
        x_i = '0;
        target_i = '0;
        w_load_i = 1'b0;
        w_addr_i = '0;
        w_data_i = '0;
        repeat (2) @(negedge clk);
        check_eq("rst.y", 32'(y_o), 32'd0);
        check_eq("rst.loss", 32'(loss_o), 32'd0);
        check_eq("rst.busy", 32'(busy_o), 32'd0);
        check_eq("rst.pulses", {29'd0, f_end_o, b_end_o, zero_end_check_o}, 32'd0);
        rst_i = 1'b1;
        @(negedge clk);

        // Scenario 1: reset during a forward pass.
        load_w(2'd0, 8'd1);
        load_w(2'd1, 8'd2);
        x_i = {8'd4, 8'd3};
        target_i = {8'd0, 8'd11};
        f0_pass_i = 1'b1;
        for (int c = 0; c <= 3; c++) @(negedge clk);
        check_eq("s1.y_before_rst", 32'(y_o), 32'h000B);
        rst_i = 1'b0;
        @(negedge clk);
        check_eq("s1.y", 32'(y_o), 32'd0);
        check_eq("s1.loss", 32'(loss_o), 32'd0);
        check_eq("s1.busy", 32'(busy_o), 32'd0);
        check_eq("s1.pulses", {29'd0, f_end_o, b_end_o, zero_end_check_o}, 32'd0);
        rst_i = 1'b1;
        f0_pass_i = 1'b0;
        @(negedge clk);
        do_pass("s1_zero_w", 1'b1, 1'b0, 1'b0, 7, 0, -1);
        check_eq("s1.w_cleared_y", 32'(y_o), 32'd0);
        check_eq("s1.w_cleared_loss", 32'(loss_o), 32'd11);
        strobe(1'b1, 1'b1, 1'b0);

        // Scenario 2: f0 exact fit.
        load_w(2'd0, 8'd1);
        load_w(2'd1, 8'd2);
        do_pass("s2", 1'b1, 1'b0, 1'b0, 7, 0, -1);
        check_eq("s2.y", 32'(y_o), 32'h000B);
        check_eq("s2.loss", 32'(loss_o), 32'd0);

        // Scenario 3: f1 exact fit raises the converged flag instead of f_end.
        do_pass("s3", 1'b0, 1'b1, 1'b0, 7, 1, -1);
        check_eq("s3.zec_set", 32'(zero_end_check_o), 32'd1);
        strobe(1'b1, 1'b0, 1'b0);
        check_eq("s3.zec_cleared", 32'(zero_end_check_o), 32'd0);

        // Scenario 4: error of 4 on output 0, then a backward pass bumps w10.
        target_i = {8'd0, 8'd15};
        do_pass("s4f", 1'b1, 1'b0, 1'b0, 7, 0, -1);
        check_eq("s4.loss", 32'(loss_o), 32'd4);
        do_pass("s4b", 1'b0, 1'b0, 1'b1, 5, 2, -1);
        strobe(1'b1, 1'b0, 1'b0);
        do_pass("s4v", 1'b1, 1'b0, 1'b0, 7, 0, -1);
        check_eq("s4.y_after_commit", 32'(y_o), 32'h000F);
        check_eq("s4.loss_after_commit", 32'(loss_o), 32'd0);

        // Scenario 5: saturation of outputs and loss.
        for (int a = 0; a < 4; a++) load_w(2'(a), 8'd127);
        x_i = {8'd127, 8'd127};
        target_i = {8'h80, 8'h80};
        strobe(1'b1, 1'b0, 1'b0);
        exp_loss = 0;
        for (int p = 0; p < 10; p++) begin
            do_pass("s5", 1'b1, 1'b0, 1'b0, 7, 0, -1);
            exp_loss = (exp_loss + 510 > 4095) ? 4095 : exp_loss + 510;
            check_eq("s5.loss", 32'(loss_o), 32'(exp_loss));
        end
        check_eq("s5.y", 32'(y_o), 32'h7F7F);

        // Scenario 6: b wins over f0, and three disabled edges delay b_end by three.
        strobe(1'b1, 1'b0, 1'b0);
        do_pass("s6b", 1'b1, 1'b0, 1'b1, 8, 2, 1);
        // Every delta saturates to -128, so each weight becomes -1.
        do_pass("s6v", 1'b1, 1'b0, 1'b0, 7, 0, -1);
        check_eq("s6.y", 32'(y_o), 32'h8080);
        check_eq("s6.loss", 32'(loss_o), 32'd0);
        strobe(1'b0, 1'b1, 1'b0);
        check_eq("zero_final.y", 32'(y_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
